// File: rtl/packet_drainer_if.sv
// Packet drainer bus interface.
// Purpose: bundles the packet RAM read port and the outgoing byte stream.
// Signals:
//   rd_addr   {sensor, byte_idx} RAM read address (drainer -> RAM)
//   rd_en     RAM read enable (drainer -> RAM)
//   q         RAM read data, combinational from rd_addr (RAM -> drainer)
//   out_data  stream byte (drainer -> sink)
//   out_valid out_data valid (drainer -> sink)
//   out_ready sink accepts on out_valid & out_ready (sink -> drainer)
//   out_sop   header byte marker (drainer -> sink)
//   out_eop   last data byte marker (drainer -> sink)
// Modports: master = drainer side, slave = RAM/sink side.
interface packet_drainer_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int LOG_SENSORS = 3,
  parameter int LOG_PACKET  = 4
);
  logic [LOG_SENSORS+LOG_PACKET-1:0] rd_addr;
  logic                              rd_en;
  logic [DATA_WIDTH-1:0]             q;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_valid;
  logic                              out_ready;
  logic                              out_sop;
  logic                              out_eop;

  modport master (
    output rd_addr, rd_en, out_data, out_valid, out_sop, out_eop,
    input  q, out_ready
  );

  modport slave (
    input  rd_addr, rd_en, out_data, out_valid, out_sop, out_eop,
    output q, out_ready
  );
endinterface

// File: rtl/packet_drainer.sv
// Packet drainer.
// Purpose: tracks which sensor slots hold a complete packet, services them
// round-robin, reads each packet byte by byte from the packet RAM and emits
// a valid/ready byte stream: one header byte (sensor id) then PACKET_LEN
// data bytes.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   pkt_ready  per-slot 1-cycle pulse: packet fully written
//   bus        RAM read port and output stream (master side)
//   pkt_done   1-cycle pulse after the last byte of a slot is accepted
//   done_id    slot id for pkt_done, held until the next pulse
//   overrun    1-cycle pulse: pkt_ready on an already-pending slot
module packet_drainer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LOG_SENSORS = 3,
  parameter int LOG_PACKET  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<LOG_SENSORS)-1:0]   pkt_ready,
  packet_drainer_if.master              bus,
  output logic                          pkt_done,
  output logic [LOG_SENSORS-1:0]        done_id,
  output logic                          overrun
);
  localparam int SENSORS    = 1 << LOG_SENSORS;
  localparam int PACKET_LEN = 1 << LOG_PACKET;
  localparam logic [LOG_PACKET-1:0] LAST_IDX = LOG_PACKET'(PACKET_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY} state_t;

  state_t                  state_q, state_d;
  logic [SENSORS-1:0]      pend_q, pend_d;
  logic [LOG_SENSORS-1:0]  cur_q, cur_d;
  logic [LOG_SENSORS-1:0]  last_q, last_d;
  logic [LOG_PACKET-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  // Slot that owns the eop byte; cur may already point at the next slot
  // while that byte waits for the sink.
  logic [LOG_SENSORS-1:0]  eop_id_q, eop_id_d;
  logic                    pkt_done_q, pkt_done_d;
  logic [LOG_SENSORS-1:0]  done_id_q, done_id_d;
  logic                    overrun_q, overrun_d;

  logic                    load;
  logic                    found;
  logic [LOG_SENSORS-1:0]  sel;
  logic [LOG_SENSORS-1:0]  cand;
  logic [SENSORS-1:0]      clr;
  logic                    rd_en_c;
  logic [LOG_SENSORS+LOG_PACKET-1:0] rd_addr_c;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cur_d       = cur_q;
    last_d      = last_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    eop_id_d    = eop_id_q;
    clr         = '0;
    rd_en_c     = 1'b0;
    rd_addr_c   = '0;
    found       = 1'b0;
    sel         = '0;
    cand        = '0;

    // The output register may advance when empty or when its byte is taken.
    load = !out_valid_q || bus.out_ready;

    // Round-robin: first pending slot strictly after last, wrapping.
    for (int k = 1; k <= SENSORS; k++) begin
      cand = last_q + LOG_SENSORS'(k);
      if (!found && pend_q[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          out_valid_d = 1'b0;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
        end
        if (found) begin
          cur_d      = sel;
          last_d     = sel;
          clr[sel]   = 1'b1;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        if (load) begin
          out_data_d  = DATA_WIDTH'(cur_q);
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = S_BODY;
        end
      end
      S_BODY: begin
        rd_en_c   = 1'b1;
        rd_addr_c = {cur_q, idx_q};
        if (load) begin
          out_data_d  = bus.q;
          out_sop_d   = 1'b0;
          out_valid_d = 1'b1;
          idx_d       = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_eop_d = 1'b1;
            eop_id_d  = cur_q;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new pulse wins over the clear of the slot being selected.
    pend_d     = (pend_q & ~clr) | pkt_ready;
    overrun_d  = |(pkt_ready & pend_q & ~clr);
    pkt_done_d = out_valid_q && bus.out_ready && out_eop_q;
    done_id_d  = pkt_done_d ? eop_id_q : done_id_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      cur_q       <= '0;
      last_q      <= LOG_SENSORS'(SENSORS - 1);
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      eop_id_q    <= '0;
      pkt_done_q  <= 1'b0;
      done_id_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      eop_id_q    <= eop_id_d;
      pkt_done_q  <= pkt_done_d;
      done_id_q   <= done_id_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.rd_en     = rd_en_c;
  assign bus.rd_addr   = rd_addr_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign pkt_done      = pkt_done_q;
  assign done_id       = done_id_q;
  assign overrun       = overrun_q;
endmodule
